// File: rtl/biriscv_fetch_pc_pkg.sv
// biriscv_fetch_pc_pkg: shared fetch state encodings, tag layout and buffer depth.
// Buffer depth is 2 when BIRISCV_FETCH_SKID_EN is defined, otherwise 1.
package biriscv_fetch_pc_pkg;
  typedef enum logic [1:0] {
    FETCH_STATE_BOOT = 2'd0,
    FETCH_STATE_RUN  = 2'd1,
    FETCH_STATE_DROP = 2'd2
  } fetch_state_t;
  localparam int TAG_PC_W    = 32;
  localparam int TAG_PRED_W  = 2;
  localparam int TAG_FAULT_W = 1;
  localparam int TAG_W       = TAG_PC_W + TAG_PRED_W;
  localparam int ENTRY_W     = 64 + TAG_W + TAG_FAULT_W;
`ifdef BIRISCV_FETCH_SKID_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif
endpackage

// File: rtl/biriscv_fetch_buf.sv
// biriscv_fetch_buf: 1- or 2-deep shift FIFO with flush, count and same-cycle push+pop.
module biriscv_fetch_buf #(
  parameter int DEPTH = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] mem_n [DEPTH];
  logic do_pop, do_push;
  assign valid = count != 2'd0;
  assign head = mem[0];
  assign do_pop = pop & valid;
  assign do_push = push & ((count < DEPTH_C) | do_pop);
  // Pop shifts toward the head; the push lands in the first free slot after that shift.
  always_comb begin
    mem_n = mem;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_pop && i + 1 < DEPTH) mem_n[i] = mem[(i + 1) % DEPTH];
      if (do_push && i == int'(count) - int'(do_pop)) mem_n[i] = push_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      mem <= '{default: '0};
    end else begin
      count <= flush ? 2'd0 : count + {1'b0, do_push} - {1'b0, do_pop};
      mem <= mem_n;
    end
  end
endmodule

// File: rtl/biriscv_fetch_pc.sv
// biriscv_fetch_pc: fetch PC owner, I-cache request issue, response buffering and redirect handling.
// BIRISCV_FETCH_SKID_EN selects a 2-entry buffer with two outstanding requests.
module biriscv_fetch_pc
  import biriscv_fetch_pc_pkg::*;
#(
  parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  output logic [31:0] pc_f_o,
  output logic        pc_accept_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        fetch_accept_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        fetch_fault_o
);
  fetch_state_t state;
  logic [31:0] pc_q;
  logic [1:0] pend_q, pend_n, buf_cnt, tag_cnt;
  logic [2:0] occ;
  logic run, resp, keep, tag_valid;
  logic [TAG_W-1:0] tag_head;
  logic [ENTRY_W-1:0] head;
  assign run = state == FETCH_STATE_RUN;
  assign resp = icache_valid_i & (pend_q != 2'd0);
  // Buffered plus in-flight entries never exceed the buffer depth, so a response always has room.
  assign occ = {1'b0, buf_cnt} + {1'b0, pend_q} - {2'b0, fetch_valid_o & fetch_accept_i};
  assign icache_rd_o = run & ~branch_request_i & (occ < 3'(FETCH_DEPTH));
  assign pc_accept_o = icache_rd_o & icache_accept_i;
  assign pend_n = pend_q + {1'b0, pc_accept_o} - {1'b0, resp};
  assign keep = resp & run & ~branch_request_i & tag_valid;
  assign pc_f_o = pc_q;
  assign icache_pc_o = {pc_q[31:3], 3'b0};
  assign {fetch_instr_o, fetch_pc_o, fetch_pred_branch_o, fetch_fault_o} = head;
  biriscv_fetch_buf #(.DEPTH(FETCH_DEPTH), .W(TAG_W)) u_tag (
    .clk(clk_i), .rst(rst_i), .flush(branch_request_i),
    .push(pc_accept_o), .push_data({pc_q, next_taken_f_i}), .pop(keep),
    .valid(tag_valid), .head(tag_head), .count(tag_cnt)
  );
  biriscv_fetch_buf #(.DEPTH(FETCH_DEPTH), .W(ENTRY_W)) u_buf (
    .clk(clk_i), .rst(rst_i), .flush(branch_request_i),
    .push(keep), .push_data({icache_inst_i, tag_head, icache_error_i}), .pop(fetch_accept_i),
    .valid(fetch_valid_o), .head(head), .count(buf_cnt)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FETCH_STATE_BOOT;
      pc_q <= BOOT_VECTOR;
      pend_q <= '0;
    end else begin
      pend_q <= pend_n;
      pc_q <= branch_request_i ? branch_pc_i : pc_accept_o ? next_pc_f_i : pc_q;
      state <= state == FETCH_STATE_BOOT ? FETCH_STATE_RUN :
               (pend_n != 2'd0 && (branch_request_i || state == FETCH_STATE_DROP)) ? FETCH_STATE_DROP :
               FETCH_STATE_RUN;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!icache_valid_i || pend_q != 2'd0) else $error("icache response with no request outstanding");
      assert (!run || tag_cnt == pend_q) else $error("tag queue out of step with outstanding count");
    end
  end
endmodule

// File: tb/tb_biriscv_fetch_pc.sv
// tb_biriscv_fetch_pc: directed bench with a 1-cycle I-cache model and a pc+8 predictor.
module tb_biriscv_fetch_pc;
  logic clk = 1'b0;
  logic rst_i, branch_request_i, icache_accept_i, icache_valid_i, icache_error_i, fetch_accept_i;
  logic [31:0] branch_pc_i, next_pc_f_i, pc_f_o, icache_pc_o, fetch_pc_o;
  logic [1:0] next_taken_f_i, fetch_pred_branch_o;
  logic pc_accept_o, icache_rd_o, fetch_valid_o, fetch_fault_o;
  logic [63:0] icache_inst_i, fetch_instr_o;
  int errors = 0;
  int checks = 0;
  int n_acc = 0;
  logic hold = 1'b0;
  logic [31:0] special_pc = 32'h80000020;
  logic [31:0] q[$];
  logic [31:0] acc_log[$];

  always #5 clk = ~clk;

  biriscv_fetch_pc dut (
    .clk_i(clk), .rst_i(rst_i), .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
    .next_pc_f_i(next_pc_f_i), .next_taken_f_i(next_taken_f_i), .pc_f_o(pc_f_o),
    .pc_accept_o(pc_accept_o), .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o),
    .icache_accept_i(icache_accept_i), .icache_valid_i(icache_valid_i), .icache_inst_i(icache_inst_i),
    .icache_error_i(icache_error_i), .fetch_accept_i(fetch_accept_i), .fetch_valid_o(fetch_valid_o),
    .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o), .fetch_pred_branch_o(fetch_pred_branch_o),
    .fetch_fault_o(fetch_fault_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record an accepted request, then drive the I-cache response and predictor.
  task automatic tick();
    logic a;
    logic [31:0] p, r;
    #1;
    a = pc_accept_o;
    p = icache_pc_o;
    if (a) begin
      n_acc++;
      acc_log.push_back(p);
    end
    @(posedge clk);
    #1;
    if (rst_i) q.delete();
    else if (a) q.push_back(p);
    if (!hold && !rst_i && q.size() > 0) begin
      r = q.pop_front();
      icache_valid_i = 1'b1;
      icache_inst_i = {~r, r};
      icache_error_i = r == special_pc;
    end else begin
      icache_valid_i = 1'b0;
      icache_inst_i = '0;
      icache_error_i = 1'b0;
    end
    next_pc_f_i = pc_f_o + 32'd8;
    next_taken_f_i = pc_f_o == special_pc ? 2'b01 : 2'b00;
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    int n = 0;
    tick();
    while (!fetch_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_valid", 64'(fetch_valid_o), 64'd1);
    chk("fetch_pc", 64'(fetch_pc_o), 64'(pc));
    chk("fetch_instr", fetch_instr_o, {~pc, pc});
    chk("fetch_pred", 64'(fetch_pred_branch_o), pc == special_pc ? 64'd1 : 64'd0);
    chk("fetch_fault", 64'(fetch_fault_o), pc == special_pc ? 64'd1 : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_i = 1'b1;
    branch_request_i = 1'b0;
    branch_pc_i = '0;
    next_pc_f_i = 32'h80000008;
    next_taken_f_i = 2'b00;
    icache_accept_i = 1'b1;
    icache_valid_i = 1'b0;
    icache_inst_i = '0;
    icache_error_i = 1'b0;
    fetch_accept_i = 1'b1;
    repeat (2) tick();
    chk("rst_pc_f", 64'(pc_f_o), 64'h80000000);
    chk("rst_icache_pc", 64'(icache_pc_o), 64'h80000000);
    chk("rst_rd", 64'(icache_rd_o), 64'd0);
    chk("rst_pc_accept", 64'(pc_accept_o), 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid_o), 64'd0);
    chk("rst_fetch_instr", fetch_instr_o, 64'd0);
    chk("rst_fetch_pc", 64'(fetch_pc_o), 64'd0);
    rst_i = 1'b0;
    // Sequential fetch from the boot vector
    expect_fetch(32'h80000000);
    expect_fetch(32'h80000008);
    expect_fetch(32'h80000010);
    chk("req0", 64'(acc_log[0]), 64'h80000000);
    chk("req1", 64'(acc_log[1]), 64'h80000008);
    chk("req2", 64'(acc_log[2]), 64'h80000010);
    // Decode stall: head held, issue stops once full
    fetch_accept_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(fetch_valid_o), 64'd1);
      chk("stall_head", 64'(fetch_pc_o), 64'h80000010);
    end
    chk("stall_rd", 64'(icache_rd_o), 64'd0);
    fetch_accept_i = 1'b1;
    expect_fetch(32'h80000018);
    expect_fetch(32'h80000020);
    expect_fetch(32'h80000028);
    // Redirect with a response still in flight
    hold = 1'b1;
    repeat (2) tick();
    branch_request_i = 1'b1;
    branch_pc_i = 32'h80001000;
    hold = 1'b0;
    tick();
    branch_request_i = 1'b0;
    #1;
    chk("redir_pc_f", 64'(pc_f_o), 64'h80001000);
    chk("redir_valid", 64'(fetch_valid_o), 64'd0);
    chk("redir_drop_rd", 64'(icache_rd_o), 64'd0);
    expect_fetch(32'h80001000);
    expect_fetch(32'h80001008);
    // Redirect coinciding with a response and an icache accept
    n = 0;
    while (!icache_valid_i && n < 10) begin
      tick();
      n++;
    end
    chk("resp_seen", 64'(icache_valid_i), 64'd1);
    branch_request_i = 1'b1;
    branch_pc_i = 32'h80002000;
    #1;
    chk("same_pc_accept", 64'(pc_accept_o), 64'd0);
    chk("same_rd", 64'(icache_rd_o), 64'd0);
    tick();
    branch_request_i = 1'b0;
    #1;
    chk("same_pc_f", 64'(pc_f_o), 64'h80002000);
    chk("same_valid", 64'(fetch_valid_o), 64'd0);
    expect_fetch(32'h80002000);
    // Throughput over 10 steady-state cycles
    n_acc = 0;
    repeat (10) tick();
`ifdef BIRISCV_FETCH_SKID_EN
    chk("throughput", 64'(n_acc >= 9), 64'd1);
`else
    chk("throughput", 64'(n_acc), 64'd5);
`endif
    // Reset mid-operation
    rst_i = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(fetch_valid_o), 64'd0);
    chk("mid_rst_pc_f", 64'(pc_f_o), 64'h80000000);
    chk("mid_rst_rd", 64'(icache_rd_o), 64'd0);
    rst_i = 1'b0;
    expect_fetch(32'h80000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
